// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: widths, requester ids and the
// pipeline tag that follows each access from grant to acknowledge.
package vram_arbiter_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BSEL_W = DEF_DATA_W / 8;
  localparam int NUM_REQ    = 4;

  typedef enum logic [1:0] {
    REQ_CPU = 2'd0,
    REQ_L1  = 2'd1,
    REQ_L2  = 2'd2,
    REQ_SPR = 2'd3
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  // One-hot requester vector for a tag; all zero for an empty slot.
  function automatic logic [NUM_REQ-1:0] tag_onehot(input tag_t tag);
    tag_onehot = '0;
    if (tag.valid) tag_onehot[tag.id] = 1'b1;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of requester handshakes and the VRAM port seen by the arbiter.
// The arbiter uses the slave view; requesters and the VRAM use the master view.
interface vram_arbiter_if #(
  parameter int ADDR_W = vram_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = vram_arbiter_pkg::DEF_DATA_W,
  parameter int BSEL_W = DATA_W / 8
);

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wrdata;
  logic [BSEL_W-1:0] cpu_wrbytesel;
  logic              cpu_write;
  logic              cpu_strobe;
  logic              cpu_ack;

  logic [ADDR_W-1:0] l1_addr;
  logic              l1_strobe;
  logic              l1_ack;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_strobe;
  logic              l2_ack;
  logic [ADDR_W-1:0] spr_addr;
  logic              spr_strobe;
  logic              spr_ack;

  logic [DATA_W-1:0] rddata;

  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wrdata;
  logic [BSEL_W-1:0] vram_wrbytesel;
  logic              vram_write;
  logic [DATA_W-1:0] vram_rddata;

  modport slave (
    input  cpu_addr, cpu_wrdata, cpu_wrbytesel, cpu_write, cpu_strobe,
    input  l1_addr, l1_strobe, l2_addr, l2_strobe, spr_addr, spr_strobe,
    input  vram_rddata,
    output cpu_ack, l1_ack, l2_ack, spr_ack, rddata,
    output vram_addr, vram_wrdata, vram_wrbytesel, vram_write
  );

  modport master (
    output cpu_addr, cpu_wrdata, cpu_wrbytesel, cpu_write, cpu_strobe,
    output l1_addr, l1_strobe, l2_addr, l2_strobe, spr_addr, spr_strobe,
    output vram_rddata,
    input  cpu_ack, l1_ack, l2_ack, spr_ack, rddata,
    input  vram_addr, vram_wrdata, vram_wrbytesel, vram_write
  );

endinterface

// File: rtl/vram_arbiter_rr_arbiter3.sv
// Three-way round-robin picker for the line renderers (bit 0 = L1, 1 = L2,
// 2 = SPR). The pointer moves past the granted renderer only when told to.
module rr_arbiter3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] grant
);

  logic [1:0] ptr;

  // Rotate so the pointer position is bit 0, isolate the lowest request,
  // then rotate back.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] start);
    logic [2:0] rot;
    logic [2:0] g;
    case (start)
      2'd1:    rot = {r[0], r[2:1]};
      2'd2:    rot = {r[1:0], r[2]};
      default: rot = r;
    endcase
    g = rot & ~(rot - 3'd1);
    case (start)
      2'd1:    pick = {g[1:0], g[2]};
      2'd2:    pick = {g[0], g[2:1]};
      default: pick = g;
    endcase
  endfunction

  assign grant = pick(req, ptr);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 2'd0;
    end else if (advance) begin
      unique case (1'b1)
        grant[0]: ptr <= 2'd1;
        grant[1]: ptr <= 2'd2;
        grant[2]: ptr <= 2'd0;
        default:  ptr <= ptr;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between the host (fixed priority) and three line
// renderers (round-robin) through a grant -> VRAM -> ack pipeline, one access per cycle.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BSEL_W = DATA_W / 8
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] strobe;
  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] busy_next;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] done;

  logic [2:0]         rr_req;
  logic [2:0]         rr_grant;
  logic               rr_advance;
  logic               host_win;

  logic               win_valid;
  req_id_e            win_id;
  logic [ADDR_W-1:0]  win_addr;

  tag_t               stage1;
  tag_t               stage2;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wrdata_q;
  logic [BSEL_W-1:0]  bsel_q;
  logic               write_q;

  assign strobe   = {bus.spr_strobe, bus.l2_strobe, bus.l1_strobe, bus.cpu_strobe};
  assign eligible = strobe & ~busy;
  assign host_win = eligible[REQ_CPU];
  assign rr_req   = eligible[3:1];

  // The pointer only moves when a renderer actually takes the slot.
  assign rr_advance = !host_win && (|rr_req);

  rr_arbiter3 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (rr_req),
    .advance (rr_advance),
    .grant   (rr_grant)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave a latch behind.
  always_comb begin
    win_valid = 1'b0;
    win_id    = REQ_CPU;
    win_addr  = '0;
    if (host_win) begin
      win_valid = 1'b1;
      win_id    = REQ_CPU;
      win_addr  = bus.cpu_addr;
    end else if (rr_grant[0]) begin
      win_valid = 1'b1;
      win_id    = REQ_L1;
      win_addr  = bus.l1_addr;
    end else if (rr_grant[1]) begin
      win_valid = 1'b1;
      win_id    = REQ_L2;
      win_addr  = bus.l2_addr;
    end else if (rr_grant[2]) begin
      win_valid = 1'b1;
      win_id    = REQ_SPR;
      win_addr  = bus.spr_addr;
    end
  end

  assign done = tag_onehot(stage2);

  // A requester stays busy from its grant until the end of its ack cycle.
  always_comb begin
    busy_next = busy & ~done;
    if (win_valid) busy_next[win_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      stage1   <= '0;
      stage2   <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      bsel_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      busy    <= busy_next;
      stage1  <= '{valid: win_valid, id: win_id};
      stage2  <= stage1;
      write_q <= host_win & bus.cpu_write;
      if (win_valid) addr_q <= win_addr;
      if (host_win) begin
        wrdata_q <= bus.cpu_wrdata;
        bsel_q   <= bus.cpu_wrbytesel;
      end
    end
  end

  assign bus.vram_addr      = addr_q;
  assign bus.vram_wrdata    = wrdata_q;
  assign bus.vram_wrbytesel = bsel_q;
  assign bus.vram_write     = write_q;

  assign bus.cpu_ack = done[REQ_CPU];
  assign bus.l1_ack  = done[REQ_L1];
  assign bus.l2_ack  = done[REQ_L2];
  assign bus.spr_ack = done[REQ_SPR];
  assign bus.rddata  = bus.vram_rddata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: VRAM model with 1-cycle read latency,
// scenario tasks with hand-computed grant/ack sequences.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int C  = 0;
  localparam int L1 = 1;
  localparam int L2 = 2;
  localparam int S  = 3;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // VRAM model: write with byte enables, registered read.
  logic [31:0] mem [0:32767];
  logic [31:0] rd_q;
  logic        pre_en = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (bus.vram_write) begin
      for (int b = 0; b < 4; b++)
        if (bus.vram_wrbytesel[b]) mem[bus.vram_addr][8*b +: 8] <= bus.vram_wrdata[8*b +: 8];
    end
    rd_q <= mem[bus.vram_addr];
  end
  assign bus.vram_rddata = rd_q;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [14:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic clear_strobes();
    bus.cpu_strobe = 1'b0;
    bus.l1_strobe  = 1'b0;
    bus.l2_strobe  = 1'b0;
    bus.spr_strobe = 1'b0;
  endtask

  task automatic apply_reset();
    clear_strobes();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // 0..3 = single ack of that requester, 4 = none, 5 = more than one.
  function automatic int ack_code();
    int n;
    int code;
    n = int'(bus.cpu_ack) + int'(bus.l1_ack) + int'(bus.l2_ack) + int'(bus.spr_ack);
    code = N;
    if (bus.cpu_ack) code = C;
    if (bus.l1_ack)  code = L1;
    if (bus.l2_ack)  code = L2;
    if (bus.spr_ack) code = S;
    if (n > 1) code = 5;
    return code;
  endfunction

  task automatic test_reset();
    bus.cpu_addr = 15'h0100;  bus.cpu_wrdata = 32'h0;  bus.cpu_wrbytesel = 4'h0;
    bus.cpu_write = 1'b0;
    bus.l1_addr = 15'h0200;  bus.l2_addr = 15'h0300;  bus.spr_addr = 15'h0400;
    rst = 1'b1;
    bus.cpu_strobe = 1'b1; bus.l1_strobe = 1'b1; bus.l2_strobe = 1'b1; bus.spr_strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ack_code() !== N) begin
        bad++; $display("FAIL reset_ack cycle %0d: got code %0d want %0d", i, ack_code(), N);
      end
      total++;
      if (bus.vram_write !== 1'b0) begin
        bad++; $display("FAIL reset_vram_write cycle %0d: got %b want 0", i, bus.vram_write);
      end
    end
    total++;
    if ({bus.vram_addr, bus.vram_wrdata, bus.vram_wrbytesel} !== '0) begin
      bad++; $display("FAIL reset_vram_regs: got addr %h data %h bsel %h want 0",
                      bus.vram_addr, bus.vram_wrdata, bus.vram_wrbytesel);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.vram_addr !== 15'h0100) begin
      bad++; $display("FAIL reset_first_grant_addr: got %h want 0100", bus.vram_addr);
    end
    clear_strobes();
    tick();
    total++;
    if (ack_code() !== C) begin
      bad++; $display("FAIL reset_first_ack: got code %0d want %0d", ack_code(), C);
    end
    tick();
    total++;
    if (ack_code() !== N) begin
      bad++; $display("FAIL reset_no_extra_ack: got code %0d want %0d", ack_code(), N);
    end
    repeat (3) tick();
  endtask

  task automatic test_host_read();
    int lat = 0;
    int code = N;
    logic [14:0] a1 = '0;
    logic [31:0] d  = '0;
    preload(15'h1234, 32'hDEADBEEF);
    bus.cpu_addr = 15'h1234;  bus.cpu_write = 1'b0;  bus.cpu_strobe = 1'b1;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (i == 1) a1 = bus.vram_addr;
      if (ack_code() !== N) begin
        lat = i; code = ack_code(); d = bus.rddata;
        bus.cpu_strobe = 1'b0;
      end
    end
    bus.cpu_strobe = 1'b0;
    total++;
    if (a1 !== 15'h1234) begin
      bad++; $display("FAIL read_vram_addr: got %h want 1234", a1);
    end
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL read_latency: got %0d want 2", lat);
    end
    total++;
    if (code !== C) begin
      bad++; $display("FAIL read_ack_who: got code %0d want %0d", code, C);
    end
    total++;
    if (d !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_data: got %h want deadbeef", d);
    end
    repeat (3) tick();
  endtask

  task automatic test_host_write();
    int wr_cnt = 0;
    int wr_at = 0;
    int ack_at = 0;
    logic [14:0] wa = '0;
    logic [31:0] wd = '0;
    logic [3:0]  wb = '0;
    preload(15'h7FFF, 32'h11223344);
    bus.cpu_addr = 15'h7FFF;  bus.cpu_wrdata = 32'hA5A5A5A5;  bus.cpu_wrbytesel = 4'b0101;
    bus.cpu_write = 1'b1;  bus.cpu_strobe = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (bus.vram_write === 1'b1) begin
        wr_cnt++; wr_at = i;
        wa = bus.vram_addr; wd = bus.vram_wrdata; wb = bus.vram_wrbytesel;
      end
      if (bus.cpu_ack === 1'b1 && ack_at == 0) begin
        ack_at = i; bus.cpu_strobe = 1'b0;
      end
    end
    bus.cpu_strobe = 1'b0;  bus.cpu_write = 1'b0;
    total++;
    if (wr_cnt !== 1 || wr_at !== 1) begin
      bad++; $display("FAIL write_pulse: got count %0d at %0d want 1 at 1", wr_cnt, wr_at);
    end
    total++;
    if ({wa, wd, wb} !== {15'h7FFF, 32'hA5A5A5A5, 4'b0101}) begin
      bad++; $display("FAIL write_values: got %h %h %b want 7fff a5a5a5a5 0101", wa, wd, wb);
    end
    total++;
    if (ack_at !== 2) begin
      bad++; $display("FAIL write_ack_cycle: got %0d want 2", ack_at);
    end
    total++;
    if (mem[15'h7FFF] !== 32'h11A533A5) begin
      bad++; $display("FAIL write_mem: got %h want 11a533a5", mem[15'h7FFF]);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int exp_seq [12] = '{C, L1, L2, C, S, L1, C, L2, S, C, L1, L2};
    logic [31:0] exp_data [4] = '{32'hC0C00001, 32'h11110002, 32'h22220003, 32'h55550004};
    apply_reset();
    preload(15'h0010, exp_data[0]);
    preload(15'h0020, exp_data[1]);
    preload(15'h0030, exp_data[2]);
    preload(15'h0040, exp_data[3]);
    bus.cpu_addr = 15'h0010;  bus.cpu_write = 1'b0;
    bus.l1_addr = 15'h0020;  bus.l2_addr = 15'h0030;  bus.spr_addr = 15'h0040;
    bus.cpu_strobe = 1'b1; bus.l1_strobe = 1'b1; bus.l2_strobe = 1'b1; bus.spr_strobe = 1'b1;
    for (int j = 1; j <= 13; j++) begin
      tick();
      if (j == 12) clear_strobes();
      if (j >= 2) begin
        total++;
        if (ack_code() !== exp_seq[j-2]) begin
          bad++; $display("FAIL b2b_order slot %0d: got code %0d want %0d", j-2, ack_code(), exp_seq[j-2]);
        end
        total++;
        if (bus.rddata !== exp_data[exp_seq[j-2]]) begin
          bad++; $display("FAIL b2b_data slot %0d: got %h want %h", j-2, bus.rddata, exp_data[exp_seq[j-2]]);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_renderers_only();
    int exp_seq [10] = '{L1, S, N, L1, S, N, L1, L2, S, N};
    apply_reset();
    bus.l1_strobe = 1'b1;  bus.spr_strobe = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      tick();
      if (j == 6) bus.l2_strobe = 1'b1;
      if (j == 9) clear_strobes();
      if (j >= 2) begin
        total++;
        if (ack_code() !== exp_seq[j-2]) begin
          bad++; $display("FAIL rr_order slot %0d: got code %0d want %0d", j-2, ack_code(), exp_seq[j-2]);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_write();
    int lat = 0;
    preload(15'h0050, 32'h0);
    bus.cpu_addr = 15'h0050;  bus.cpu_wrdata = 32'h12345678;  bus.cpu_wrbytesel = 4'hF;
    bus.cpu_write = 1'b1;  bus.cpu_strobe = 1'b1;
    tick();
    total++;
    if (bus.vram_write !== 1'b1) begin
      bad++; $display("FAIL midrst_stage1_write: got %b want 1", bus.vram_write);
    end
    rst = 1'b1;  bus.cpu_strobe = 1'b0;
    tick();
    total++;
    if (bus.vram_write !== 1'b0 || bus.cpu_ack !== 1'b0) begin
      bad++; $display("FAIL midrst_after_edge: got write %b ack %b want 0 0", bus.vram_write, bus.cpu_ack);
    end
    rst = 1'b0;
    tick();
    total++;
    if (ack_code() !== N || bus.vram_write !== 1'b0) begin
      bad++; $display("FAIL midrst_dropped: got code %0d write %b want %0d 0", ack_code(), bus.vram_write, N);
    end
    bus.cpu_wrdata = 32'hCAFEF00D;  bus.cpu_strobe = 1'b1;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (bus.cpu_ack === 1'b1) begin
        lat = i; bus.cpu_strobe = 1'b0;
      end
    end
    bus.cpu_strobe = 1'b0;  bus.cpu_write = 1'b0;
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL midrst_rerequest_latency: got %0d want 2", lat);
    end
    total++;
    if (mem[15'h0050] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL midrst_rerequest_mem: got %h want cafef00d", mem[15'h0050]);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_host_read();
    test_host_write();
    test_back_to_back();
    test_renderers_only();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
